// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, the controller state type and the
// leading-zero blanking helper for the BCD sweep controller.
//   BCD_OVF   : result written for source values above 999 (solid glyph)
//   BCD_BLANK : nibble code the glyph logic renders as a blank cell
package bcd_pkg;

   localparam int BCD_L     = 47;
   localparam int BCD_WBITS = 10;
   localparam int BCD_DBITS = 12;

   localparam logic [11:0] BCD_OVF   = 12'hFFF;
   localparam logic [3:0]  BCD_BLANK = 4'hF;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, CONV, WRITE, DONE} state_t;

   // Blank the hundreds digit if zero, then the tens digit if it is also
   // zero. The units digit always shows; overflow passes through.
   function automatic logic [11:0] bcd_blank(input logic [11:0] d);
      logic [11:0] r;
      r = d;
      if (d != BCD_OVF && d[11:8] == 4'h0) begin
         r[11:8] = BCD_BLANK;
         if (d[7:4] == 4'h0) r[7:4] = BCD_BLANK;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_sweep_ctrl_dabble_conv.sv
// dabble_conv: multi-cycle binary-to-BCD converter (double dabble).
//   clk, RSTn : clock, async active-low reset
//   cv_start  : load cv_in and begin WBITS shift cycles
//   cv_in     : binary source word
//   cv_done   : high during the final shift cycle
//   cv_dout   : 3-digit BCD result, valid from the cycle after cv_done and
//               held until the next conversion finishes; 12'hFFF if cv_in>999
module dabble_conv
   import bcd_pkg::*;
#(
   parameter int WBITS = BCD_WBITS,
   parameter int DBITS = BCD_DBITS
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic             cv_start,
   input  logic [WBITS-1:0] cv_in,
   output logic             cv_done,
   output logic [DBITS-1:0] cv_dout
);

   localparam int SW = 16 + WBITS;
   localparam int CW = $clog2(WBITS + 1);

   logic [SW-1:0]    r_sr;
   logic [CW-1:0]    r_cnt;
   logic             r_ovf;
   logic [DBITS-1:0] r_dout;
   logic [15:0]      w_adj;
   logic [SW-1:0]    w_next;

   // Add-3 correction on every BCD nibble, then one left shift.
   always_comb begin
      w_adj = '0;
      for (int n = 0; n < 4; n++) begin
         if (r_sr[WBITS + 4*n +: 4] >= 4'd5)
            w_adj[4*n +: 4] = r_sr[WBITS + 4*n +: 4] + 4'd3;
         else
            w_adj[4*n +: 4] = r_sr[WBITS + 4*n +: 4];
      end
      w_next = {w_adj, r_sr[WBITS-1:0]} << 1;
   end

   assign cv_done = (r_cnt == CW'(1));
   assign cv_dout = r_dout;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_dout <= '0;
      end else if (cv_start) begin
         r_sr  <= {16'h0, cv_in};
         r_cnt <= CW'(WBITS);
         r_ovf <= (32'(cv_in) > 32'd999);
      end else if (r_cnt != '0) begin
         r_sr  <= w_next;
         r_cnt <= r_cnt - CW'(1);
         // Capture the post-shift value so the result is ready in WRITE.
         if (cv_done)
            r_dout <= r_ovf ? DBITS'(BCD_OVF) : w_next[WBITS +: DBITS];
      end
   end

endmodule

// File: rtl/bcd_sweep_ctrl.sv
// bcd_sweep_ctrl: per-frame scheduler converting the L displayed words to
// BCD and writing them into the character buffer.
//   clk, RSTn       : clock, async active-low reset
//   vsync           : frame sync level, rising edge requests a sweep
//   run             : sweep enable; low at a word write aborts the sweep
//   ovr_clr         : clears the sticky overrun flag (a set wins)
//   rd_idx/rd_data  : source read port, data valid one cycle after index
//   wr_en/addr/data : character buffer write port
//   busy, done, ovr : sweep in progress, end-of-sweep pulse, overrun sticky
// Build option: define BCD_ZERO_BLANK_EN to blank leading zero digits.
module bcd_sweep_ctrl
   import bcd_pkg::*;
#(
   parameter int L     = BCD_L,
   parameter int WBITS = BCD_WBITS,
   parameter int DBITS = BCD_DBITS,
   parameter int IDXW  = 6
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic             vsync,
   input  logic             run,
   input  logic             ovr_clr,
   output logic [IDXW-1:0]  rd_idx,
   input  logic [WBITS-1:0] rd_data,
   output logic             wr_en,
   output logic [IDXW-1:0]  wr_addr,
   output logic [DBITS-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             ovr
);

   localparam logic [IDXW-1:0] LAST = IDXW'(L - 1);

   state_t           r_state, w_nxt;
   logic [IDXW-1:0]  r_idx;
   logic             r_vs_q, r_ovr;
   logic [DBITS-1:0] r_wr_data, w_res, w_cv_dout;
   logic             w_trig, w_cv_start, w_cv_done;

   dabble_conv #(.WBITS(WBITS), .DBITS(DBITS)) u_conv (
      .clk      (clk),
      .RSTn     (RSTn),
      .cv_start (w_cv_start),
      .cv_in    (rd_data),
      .cv_done  (w_cv_done),
      .cv_dout  (w_cv_dout)
   );

`ifdef BCD_ZERO_BLANK_EN
   assign w_res = bcd_blank(w_cv_dout);
`else
   assign w_res = w_cv_dout;
`endif

   assign w_trig = vsync & ~r_vs_q;

   always_comb begin
      w_nxt      = r_state;
      w_cv_start = 1'b0;
      case (r_state)
         IDLE:  if (w_trig && run) w_nxt = FETCH;
         FETCH: w_nxt = LOAD;
         LOAD: begin
            w_cv_start = 1'b1;
            w_nxt      = CONV;
         end
         CONV:  if (w_cv_done) w_nxt = WRITE;
         WRITE: begin
            if (r_idx == LAST) w_nxt = DONE;
            else if (!run)     w_nxt = IDLE;
            else               w_nxt = FETCH;
         end
         DONE:  w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_vs_q    <= 1'b0;
         r_ovr     <= 1'b0;
         r_wr_data <= '0;
      end else begin
         r_state <= w_nxt;
         r_vs_q  <= vsync;
         // idx only moves on entry to FETCH, so rd_idx holds elsewhere.
         if (r_state == IDLE && w_nxt == FETCH)
            r_idx <= '0;
         else if (r_state == WRITE && w_nxt == FETCH)
            r_idx <= r_idx + IDXW'(1);
         if (w_trig && busy) r_ovr <= 1'b1;
         else if (ovr_clr)   r_ovr <= 1'b0;
         if (r_state == WRITE) r_wr_data <= w_res;
      end
   end

   assign busy    = (r_state == FETCH) || (r_state == LOAD) ||
                    (r_state == CONV)  || (r_state == WRITE);
   assign done    = (r_state == DONE);
   assign wr_en   = (r_state == WRITE);
   assign rd_idx  = r_idx;
   assign wr_addr = r_idx;
   assign wr_data = (r_state == WRITE) ? w_res : r_wr_data;
   assign ovr     = r_ovr;

endmodule
